mem_responder: RTL and testbench
================================

# mem_responder

Word-addressed memory responder forming the far end of the multi-cycle CPU's address/data register path. It accepts one read or write request per transaction from the CPU's registered address/data outputs, inserts a parameterised number of wait states, performs the access and returns a one-cycle `ready` pulse with read data and an error flag. It stands in for main memory in multi-cycle CPU simulations and on the FPGA build.

## Interface
- `DEPTH_LOG2`, default 10: memory holds 2^DEPTH_LOG2 32-bit words.
- `WAIT`, default 2: wait cycles inserted between accept and access; legal range 0..15.

- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  reset; one clock; reset is asynchronous and active-low.
- `req`  input  1  request valid, sampled only in IDLE.
- `we`  input  1  1 = write, 0 = read; captured at accept.
- `addr`  input  32  byte address; word index = `addr[DEPTH_LOG2+1:2]`.
- `wdata`  input  32  write data; captured at accept.
- `rdata`  output  32  read data; registered, held until the next response.
- `ready`  output  1  one-cycle response pulse.
- `err`  output  1  error status; valid while `ready`=1, otherwise 0.
- `busy`  output  1  1 whenever state ≠ IDLE.

## Operation
- FSM states and transitions:
  - IDLE: if `req`=1 at the edge, go to WAITING. Capture `we`, `addr` and `wdata` into internal registers, and load `cnt`=WAIT.
  - WAITING: if `cnt`≠0, decrement `cnt`. If `cnt`=0, perform the access and go to RESP.
  - RESP: go to IDLE. `req` is ignored.
- The access uses the captured values only. Input changes after accept have no effect.
- Range check: if captured `addr[31:DEPTH_LOG2+2]`≠0:
  - set `err`=1;
  - perform no write;
  - set `rdata`=0.
- Read access: `rdata` ← mem[index].
- Write access:
  - mem[index] ← captured wdata;
  - `rdata` ← captured wdata (write-through echo).
- `ready`=1 and `err` are registered, and both are asserted only in RESP.
- Memory contents are not reset. Simulation initialises them to 0.

## Timing
- Accept occurs at edge k, when the state is IDLE and `req`=1.
- The access and the RESP entry occur at edge k+WAIT+1. `ready` is high during the cycle after that edge.
- The FSM returns to IDLE at edge k+WAIT+2. The earliest next accept is edge k+WAIT+3. Throughput is one transaction per WAIT+3 cycles.
- `busy` rises at edge k and falls at edge k+WAIT+2.
- With WAIT=0, WAITING lasts exactly one cycle.
- `req` held high continuously is accepted again at every first IDLE edge. No request is queued while busy.
- Reset values: state=IDLE, `cnt`=0, `ready`=0, `err`=0, `busy`=0, `rdata`=0.
- Reset asserted mid-transaction:
  - The transaction is aborted and no response is produced.
  - A write is lost if reset precedes edge k+WAIT+1.
- Reset deasserted: the first possible accept is the first rising edge with `rst_n`=1.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - A captured `addr[1:0]`≠0 sets `err`=1, with no write and `rdata`=0.
  - Misalignment and out-of-range both report through `err`; the two conditions are ORed.
- Not defined: `addr[1:0]` is ignored and the access uses the word index only.

## Test plan
- Reset, then read: WAIT=2, read `addr`=0x0 accepted at edge 1. `ready`=1 after edge 4 with `rdata`=0x00000000 and `err`=0. `busy` is high for edges 1–4.
- Write then read: write 0xDEADBEEF to 0x10, then read 0x10. The first `ready` returns `rdata`=0xDEADBEEF as the echo. The second read returns 0xDEADBEEF, and responses are spaced 5 cycles apart.
- Out of range: DEPTH_LOG2=10, write to 0x00001000. `ready`=1 with `err`=1 and `rdata`=0. A subsequent read of 0x0 returns the unchanged old value.
- Input stability: change `addr` and `wdata` on the cycle after accept. The access uses the captured values and the memory at the new address is untouched.
- Reset mid-operation: assert `rst_n`=0 while in WAITING during a write to 0x20.
  - All outputs go to 0 immediately.
  - No `ready` pulse appears.
  - A subsequent read of 0x20 returns the prior value.
- Misalignment, with `MEM_ALIGN_CHECK_EN` defined: read 0x13 → `err`=1. Without the macro, a read of 0x13 returns mem[4] with `err`=0.

Source files
------------

// File: rtl/mem_responder.sv
// Word-addressed memory responder: accepts one request, waits WAIT cycles, accesses, pulses ready.
// Optional macro MEM_ALIGN_CHECK_EN: misaligned byte addresses also report err.
module mem_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned WAIT       = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0]  WAIT_CNT = 4'(WAIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAITING,
    S_RESP
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        ready_q;
  logic        err_q;

  logic [31:0] mem_q [DEPTH];

  logic [DEPTH_LOG2-1:0] idx;
  logic                  addr_bad;
  logic                  access;
  logic                  wr_en;
  logic [31:0]           rdata_d;

  function automatic logic addr_fault(input logic [31:0] a);
    logic f;
    f = ((a >> (DEPTH_LOG2 + 2)) != 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
    f = f | (a[1:0] != 2'b00);
`endif
    return f;
  endfunction

  assign idx      = addr_q[DEPTH_LOG2+1:2];
  assign addr_bad = addr_fault(addr_q);
  assign access   = (state_q == S_WAITING) && (cnt_q == 4'd0);
  assign wr_en    = access && we_q && !addr_bad;

  // Faulted accesses return zero; writes echo the captured data back.
  always_comb begin
    rdata_d = 32'd0;
    if (!addr_bad) begin
      rdata_d = we_q ? wdata_q : mem_q[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[idx] <= wdata_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          if (req) begin
            state_q <= S_WAITING;
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            cnt_q   <= WAIT_CNT;
          end
        end
        S_WAITING: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= S_RESP;
            rdata_q <= rdata_d;
            ready_q <= 1'b1;
            err_q   <= addr_bad;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          err_q   <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed scoreboard bench for mem_responder (DEPTH_LOG2=10, WAIT=2).
module tb_mem_responder;

  localparam int DL2 = 10;
  localparam int WT  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;

  always #5 clk = ~clk;

  mem_responder #(
    .DEPTH_LOG2(DL2),
    .WAIT      (WT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .we   (we),
    .addr (addr),
    .wdata(wdata),
    .rdata(rdata),
    .ready(ready),
    .err  (err),
    .busy (busy)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks     = 0;
  int   errors     = 0;
  int   cyc        = 0;
  int   last_ready = 0;
  int   last_gap   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Response monitor: every ready pulse pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (ready === 1'b1) begin
      last_gap   = cyc - last_ready;
      last_ready = cyc;
      if (sb.size() == 0) begin
        chk("unexpected_ready", {31'd0, ready}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("resp_rdata", rdata, e.rdata);
        chk("resp_err", {31'd0, err}, {31'd0, e.err});
      end
    end
  end

  task automatic push_exp(input logic [31:0] r, input logic e);
    exp_t x;
    x.rdata = r;
    x.err   = e;
    sb.push_back(x);
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] er, input logic ee, input bit scramble);
    int n;
    bit busy_ok;
    push_exp(er, ee);
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    n       = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        req = 1'b0;
        if (scramble) begin
          we    = ~w;
          addr  = 32'h0000_0040;
          wdata = 32'h5A5A_5A5A;
        end
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end while (ready !== 1'b1 && n < 20);
    chk("latency", 32'(n), 32'(WT + 2));
    chk("busy_during", {31'd0, busy_ok}, 32'd1);
    @(negedge clk);
    chk("busy_after", {31'd0, busy}, 32'd0);
    chk("ready_after", {31'd0, ready}, 32'd0);
    chk("err_after", {31'd0, err}, 32'd0);
    chk("rdata_held", rdata, er);
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ready !== 1'b1 && n < 20);
    chk(tag, {31'd0, ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw;
    rst_n = 1'b0;
    req   = 1'b0;
    we    = 1'b0;
    addr  = 32'd0;
    wdata = 32'd0;
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // First read after reset sees zero-initialised memory.
    issue(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Write then read with req held high: responses 5 cycles apart.
    push_exp(32'hDEAD_BEEF, 1'b0);
    push_exp(32'hDEAD_BEEF, 1'b0);
    req   = 1'b1;
    we    = 1'b1;
    addr  = 32'h10;
    wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    we = 1'b0;
    wait_ready("b2b_first_ready");
    @(negedge clk);
    @(negedge clk);
    chk("b2b_second_accept", {31'd0, busy}, 32'd1);
    req = 1'b0;
    wait_ready("b2b_second_ready");
    @(negedge clk);
    chk("b2b_gap", 32'(last_gap), 32'd5);

    // Out-of-range write must not alias onto word 0.
    issue(1'b1, 32'h0, 32'h1111_1111, 32'h1111_1111, 1'b0, 1'b0);
    issue(1'b1, 32'h0000_1000, 32'hCAFE_F00D, 32'h0, 1'b1, 1'b0);
    issue(1'b0, 32'h0, 32'h0, 32'h1111_1111, 1'b0, 1'b0);
    issue(1'b0, 32'h8000_0000, 32'h0, 32'h0, 1'b1, 1'b0);

    // Inputs changed after accept are ignored.
    issue(1'b1, 32'h30, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 1'b1);
    issue(1'b0, 32'h30, 32'h0, 32'hA5A5_A5A5, 1'b0, 1'b0);
    issue(1'b0, 32'h40, 32'h0, 32'h0, 1'b0, 1'b0);

    // Reset during WAITING aborts the write and the response.
    issue(1'b1, 32'h20, 32'h2222_2222, 32'h2222_2222, 1'b0, 1'b0);
    req   = 1'b1;
    we    = 1'b1;
    addr  = 32'h20;
    wdata = 32'h3333_3333;
    @(negedge clk);
    req = 1'b0;
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", {31'd0, ready}, 32'd0);
    chk("abort_err", {31'd0, err}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ready === 1'b1) saw = 1'b1;
    end
    chk("abort_no_ready", {31'd0, saw}, 32'd0);
    issue(1'b0, 32'h20, 32'h0, 32'h2222_2222, 1'b0, 1'b0);

    // Misaligned read of 0x13.
`ifdef MEM_ALIGN_CHECK_EN
    issue(1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1'b0);
`else
    issue(1'b0, 32'h13, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
`endif

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
